// File: rtl/motion_pkg.sv
// motion_pkg: shared definitions for the motion ramp controller.
//   - direction codes driven to the four-motor direction/PWM stage
//   - sequencer state encoding
//   - clamp_target(): command (direction, speed) -> duty target
package motion_pkg;

  localparam logic [1:0] DIR_FWD   = 2'd0;
  localparam logic [1:0] DIR_LEFT  = 2'd1;
  localparam logic [1:0] DIR_RIGHT = 2'd2;
  localparam logic [1:0] DIR_STOP  = 2'd3;

  // Width of the clamp helper arguments; callers zero-extend into it.
  localparam int unsigned CLAMP_W = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RAMP_DN = 2'd1,
    RAMP_UP = 2'd2,
    RUN     = 2'd3
  } state_t;

  // Stop maps to zero duty; any other direction is limited to the period.
  function automatic logic [CLAMP_W-1:0] clamp_target(
    input logic [1:0]         cmd_dir,
    input logic [CLAMP_W-1:0] speed,
    input logic [CLAMP_W-1:0] limit
  );
    if (cmd_dir == DIR_STOP) begin
      return '0;
    end
    return (speed > limit) ? limit : speed;
  endfunction

endpackage

// File: rtl/ramp_tick_gen.sv
// ramp_tick_gen: free-running prescaler that paces the duty ramp.
// The counter runs 0..STEP_DIV-1 and tick_c is high for the single cycle in
// which it sits at STEP_DIV-1.
// Ports:
//   clk     in   system clock
//   rst     in   synchronous reset, active-high (counter to 0)
//   tick_c  out  one-cycle ramp tick (decoded from the counter)
module ramp_tick_gen #(
  parameter int unsigned STEP_DIV = 859
) (
  input  logic clk,
  input  logic rst,
  output logic tick_c
);

  localparam int unsigned CNT_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STEP_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Prescaler counter, wraps at STEP_DIV-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick_c = (cnt == CNT_MAX);

endmodule

// File: rtl/motion_ramp_ctrl.sv
// motion_ramp_ctrl: sequencer between the remote-command decoder and the
// four-motor direction/PWM stage. Accepts (direction, speed) commands over a
// valid/ready handshake, ramps the shared duty in STEP increments once per
// ramp tick, and always brings the duty to zero before changing direction so
// the H-bridges never see a live reversal. e_stop forces an immediate stop.
//
// Build option MOTION_WDOG_EN: when defined, a command-link watchdog counts
// ramp ticks outside IDLE and, after WDOG_TICKS ticks with no accepted command,
// pulses wdog_trip and applies an internal stop. When undefined the watchdog
// is not built, wdog_trip is tied low and the last command is held forever.
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous reset, active-high
//   cmd_valid  in   command present
//   cmd_ready  out  command accepted when valid & ready (combinational)
//   cmd_dir    in   0 fwd, 1 left, 2 right, 3 stop
//   cmd_speed  in   target duty in clk cycles
//   e_stop     in   level emergency stop
//   dir        out  direction code to the PWM stage
//   period     out  PWM period (constant PERIOD)
//   duty       out  shared duty, fanned out to all four wheels by the parent
//   busy       out  ramp in progress
//   wdog_trip  out  one-cycle pulse on watchdog expiry
module motion_ramp_ctrl
  import motion_pkg::*;
#(
  parameter int unsigned N          = 32,
  parameter int unsigned PERIOD     = 85899,
  parameter int unsigned STEP_DIV   = 859,
  parameter int unsigned STEP       = 4295,
  parameter int unsigned WDOG_TICKS = 500
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_dir,
  input  logic [N-1:0] cmd_speed,
  input  logic         e_stop,
  output logic [1:0]   dir,
  output logic [N-1:0] period,
  output logic [N-1:0] duty,
  output logic         busy,
  output logic         wdog_trip
);

  localparam logic [N-1:0] PERIOD_N = N'(PERIOD);
  localparam logic [N-1:0] STEP_N   = N'(STEP);

  // Elaboration-time parameter sanity.
  if (STEP_DIV < 2) begin : g_bad_step_div
    $error("motion_ramp_ctrl: STEP_DIV must be at least 2");
  end
  if (WDOG_TICKS == 0) begin : g_bad_wdog_ticks
    $error("motion_ramp_ctrl: WDOG_TICKS must be nonzero");
  end

  state_t       state, state_nx;
  logic [1:0]   dir_nx;
  logic [N-1:0] duty_nx;
  logic [N-1:0] tgt, tgt_nx;
  logic [1:0]   pend_dir, pend_dir_nx;
  logic [N-1:0] pend_tgt, pend_tgt_nx;
  logic         pend_vld, pend_vld_nx;
  logic         busy_nx;

  logic         tick;
  logic         accept;
  logic         expire;
  logic [N-1:0] target;
  logic [1:0]   req_dir;
  logic [N-1:0] req_tgt;
  logic [N:0]   up_sum;
  logic [N:0]   dn_floor;

  ramp_tick_gen #(
    .STEP_DIV (STEP_DIV)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .tick_c (tick)
  );

  assign period    = PERIOD_N;
  assign cmd_ready = ((state == IDLE) || (state == RUN)) && !e_stop && !rst;
  assign accept    = cmd_valid && cmd_ready;
  assign target    = N'(clamp_target(cmd_dir, CLAMP_W'(cmd_speed), CLAMP_W'(PERIOD_N)));

`ifdef MOTION_WDOG_EN
  localparam int unsigned WD_W = $clog2(WDOG_TICKS + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_TICKS - 1);

  logic [WD_W-1:0] wd_cnt, wd_cnt_nx;
  logic            wd_armed, wd_armed_nx;

  // Expiry is only possible while armed, i.e. after an accept and before the
  // trip; the count then stays at zero until the next accepted command.
  assign expire = (state != IDLE) && wd_armed && tick && (wd_cnt == WD_LAST);

  // Watchdog next-state: accept beats expiry, e_stop beats everything.
  always_comb begin
    wd_cnt_nx   = wd_cnt;
    wd_armed_nx = wd_armed;
    if (e_stop) begin
      wd_cnt_nx = '0;
    end else if (accept) begin
      wd_cnt_nx   = '0;
      wd_armed_nx = 1'b1;
    end else if (expire) begin
      wd_cnt_nx   = '0;
      wd_armed_nx = 1'b0;
    end else if (state == IDLE) begin
      wd_cnt_nx = '0;
    end else if (tick && wd_armed) begin
      wd_cnt_nx = wd_cnt + WD_W'(1);
    end
  end

  // Watchdog registers and trip pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt    <= '0;
      wd_armed  <= 1'b0;
      wdog_trip <= 1'b0;
    end else begin
      wd_cnt    <= wd_cnt_nx;
      wd_armed  <= wd_armed_nx;
      wdog_trip <= expire && !e_stop && !accept;
    end
  end
`else
  assign expire    = 1'b0;
  assign wdog_trip = 1'b0;
`endif

  // Sequencer next-state and datapath.
  always_comb begin
    state_nx    = state;
    dir_nx      = dir;
    duty_nx     = duty;
    tgt_nx      = tgt;
    pend_dir_nx = pend_dir;
    pend_tgt_nx = pend_tgt;
    pend_vld_nx = pend_vld;
    req_dir     = cmd_dir;
    req_tgt     = target;
    // N+1-bit sums so neither the up step nor the down threshold can wrap.
    up_sum      = {1'b0, duty} + {1'b0, STEP_N};
    dn_floor    = {1'b0, tgt} + {1'b0, STEP_N};

    // A watchdog expiry behaves exactly like an accepted stop command.
    if (expire && !accept) begin
      req_dir = DIR_STOP;
      req_tgt = '0;
    end

    if (e_stop) begin
      state_nx    = IDLE;
      duty_nx     = '0;
      dir_nx      = DIR_STOP;
      tgt_nx      = '0;
      pend_vld_nx = 1'b0;
    end else if (accept || expire) begin
      if ((req_dir == dir) || (duty == '0)) begin
        // Same direction or already stopped: retarget directly.
        if (!((req_dir == DIR_STOP) && (duty != '0))) begin
          dir_nx = req_dir;
        end
        tgt_nx      = req_tgt;
        pend_vld_nx = 1'b0;
        if (req_tgt > duty) begin
          state_nx = RAMP_UP;
        end else if (req_tgt < duty) begin
          state_nx = RAMP_DN;
        end else if (req_tgt == '0) begin
          state_nx = IDLE;
        end else begin
          state_nx = RUN;
        end
      end else begin
        // Direction change under load: park the request, ramp to zero first.
        pend_dir_nx = req_dir;
        pend_tgt_nx = req_tgt;
        pend_vld_nx = 1'b1;
        tgt_nx      = '0;
        state_nx    = RAMP_DN;
      end
    end else if (tick) begin
      case (state)
        RAMP_UP: begin
          duty_nx = (up_sum > {1'b0, tgt}) ? tgt : up_sum[N-1:0];
          if (duty_nx == tgt) begin
            state_nx = RUN;
          end
        end
        RAMP_DN: begin
          duty_nx = ({1'b0, duty} > dn_floor) ? (duty - STEP_N) : tgt;
          if (duty_nx == tgt) begin
            if (pend_vld) begin
              // Bridges are idle at zero duty: safe to switch direction now.
              dir_nx      = pend_dir;
              tgt_nx      = pend_tgt;
              pend_vld_nx = 1'b0;
              state_nx    = (pend_tgt == '0) ? IDLE : RAMP_UP;
            end else if (tgt != '0) begin
              state_nx = RUN;
            end else begin
              dir_nx   = DIR_STOP;
              state_nx = IDLE;
            end
          end
        end
        default: begin
        end
      endcase
    end

    busy_nx = (state_nx == RAMP_UP) || (state_nx == RAMP_DN);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      dir      <= DIR_STOP;
      duty     <= '0;
      tgt      <= '0;
      pend_dir <= DIR_STOP;
      pend_tgt <= '0;
      pend_vld <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nx;
      dir      <= dir_nx;
      duty     <= duty_nx;
      tgt      <= tgt_nx;
      pend_dir <= pend_dir_nx;
      pend_tgt <= pend_tgt_nx;
      pend_vld <= pend_vld_nx;
      busy     <= busy_nx;
    end
  end

endmodule

// File: tb/tb_motion_ramp_ctrl.sv
// tb_motion_ramp_ctrl: self-checking bench for motion_ramp_ctrl with a small
// configuration (PERIOD=100, STEP_DIV=4, STEP=25, WDOG_TICKS=8). Works with
// and without MOTION_WDOG_EN. The reference model keeps the motion plan as a
// queue of ramp legs (target duty + direction to apply on arrival).
module tb_motion_ramp_ctrl;

  localparam int N_W     = 32;
  localparam int PER     = 100;
  localparam int DIVV    = 4;
  localparam int STP     = 25;
  localparam int WDT     = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [1:0]      cmd_dir;
  logic [N_W-1:0]  cmd_speed;
  logic            e_stop;
  logic [1:0]      dir;
  logic [N_W-1:0]  period;
  logic [N_W-1:0]  duty;
  logic            busy;
  logic            wdog_trip;

  motion_ramp_ctrl #(
    .N          (N_W),
    .PERIOD     (PER),
    .STEP_DIV   (DIVV),
    .STEP       (STP),
    .WDOG_TICKS (WDT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dir   (cmd_dir),
    .cmd_speed (cmd_speed),
    .e_stop    (e_stop),
    .dir       (dir),
    .period    (period),
    .duty      (duty),
    .busy      (busy),
    .wdog_trip (wdog_trip)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int ticks_seen = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int tgt;
    int end_dir;   // direction applied when the leg completes, -1 = keep
  } leg_t;

  leg_t legs[$];
  int   m_dir = 3;
  int   m_duty = 0;
  int   m_tcnt = 0;
  int   m_wcnt = 0;
  bit   m_armed = 0;
  bit   m_trip = 0;
  bit   m_tick = 0;
  bit   m_acc = 0;

  function automatic int clampv(input logic [1:0] d, input logic [31:0] s);
    if (d == 2'd3) return 0;
    if (s > 32'(PER)) return PER;
    return int'(s);
  endfunction

  // Replace the motion plan with the one implied by a new command.
  task automatic plan(input int d, input int t);
    leg_t lg;
    legs.delete();
    if (d == m_dir || m_duty == 0) begin
      if (!(d == 3 && m_duty != 0)) m_dir = d;
      if (t != m_duty) begin
        lg.tgt = t;
        lg.end_dir = (t == 0) ? 3 : -1;
        legs.push_back(lg);
      end
    end else begin
      lg.tgt = 0;
      lg.end_dir = d;
      legs.push_back(lg);
      if (t != 0) begin
        lg.tgt = t;
        lg.end_dir = -1;
        legs.push_back(lg);
      end
    end
  endtask

  task automatic model_update(input bit r, input bit v, input logic [1:0] d,
                              input logic [31:0] s, input bit es);
    bit rdy, idle_pre, expire;
    int g;
    m_trip = 0;
    m_acc  = 0;
    if (r) begin
      m_dir = 3; m_duty = 0; legs.delete();
      m_tcnt = 0; m_wcnt = 0; m_armed = 0; m_tick = 0;
      return;
    end
    rdy      = (legs.size() == 0) && !es;
    m_tick   = (m_tcnt == DIVV - 1);
    m_tcnt   = (m_tcnt + 1) % DIVV;
    idle_pre = (legs.size() == 0) && (m_duty == 0);
    m_acc    = v && rdy;
    if (es) begin
      m_dir = 3; m_duty = 0; legs.delete(); m_wcnt = 0;
      return;
    end
    expire = 0;
`ifdef MOTION_WDOG_EN
    expire = !idle_pre && m_armed && m_tick && (m_wcnt == WDT - 1);
`endif
    if (m_acc) begin
      m_wcnt = 0; m_armed = 1;
      plan(int'(d), clampv(d, s));
    end else if (expire) begin
      m_trip = 1; m_wcnt = 0; m_armed = 0;
      plan(3, 0);
    end else begin
      if (m_tick && legs.size() != 0) begin
        g = legs[0].tgt;
        if (m_duty < g) m_duty = (m_duty + STP > g) ? g : m_duty + STP;
        else            m_duty = (m_duty - STP < g) ? g : m_duty - STP;
        if (m_duty == g) begin
          if (legs[0].end_dir >= 0) m_dir = legs[0].end_dir;
          void'(legs.pop_front());
        end
      end
      if (idle_pre) m_wcnt = 0;
      else if (m_tick && m_armed) m_wcnt++;
    end
  endtask

  // One clock: check cmd_ready before the edge, advance model, check outputs.
  task automatic cycle();
    #1;
    check("cmd_ready", cmd_ready, (!rst && !e_stop && legs.size() == 0) ? 1 : 0);
    @(posedge clk);
    model_update(rst, cmd_valid, cmd_dir, cmd_speed, e_stop);
    @(negedge clk);
    check("dir", dir, m_dir);
    check("duty", duty, m_duty);
    check("busy", busy, (legs.size() != 0) ? 1 : 0);
    check("wdog_trip", wdog_trip, m_trip);
    if (m_tick) ticks_seen++;
  endtask

  task automatic wait_ticks(input int n);
    int guard;
    guard = 0;
    ticks_seen = 0;
    while (ticks_seen < n && guard < 200) begin
      cycle();
      guard++;
    end
    if (ticks_seen < n) check("tick_timeout", ticks_seen, n);
  endtask

  task automatic offer(input logic [1:0] d, input logic [31:0] s);
    cmd_valid = 1'b1; cmd_dir = d; cmd_speed = s;
    cycle();
    cmd_valid = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          valid;
    logic [1:0]  d;
    logic [31:0] spd;
    int          ticks;
    bit          exp_ready;
    int          exp_dir;
    int          exp_duty;
    bit          exp_busy;
  } vec_t;

  localparam int NV = 18;
  vec_t tbl[NV];

  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0d checks, expected completion", n_checks);
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1'b1, 2'd0, 32'd60,  0, 1'b1, 0, 0,   1'b1};
    tbl[1]  = '{1'b0, 2'd0, 32'd0,   1, 1'b0, 0, 25,  1'b1};
    tbl[2]  = '{1'b0, 2'd0, 32'd0,   1, 1'b0, 0, 50,  1'b1};
    tbl[3]  = '{1'b0, 2'd0, 32'd0,   1, 1'b0, 0, 60,  1'b0};
    tbl[4]  = '{1'b1, 2'd1, 32'd100, 0, 1'b1, 0, 60,  1'b1};
    tbl[5]  = '{1'b0, 2'd0, 32'd0,   1, 1'b0, 0, 35,  1'b1};
    tbl[6]  = '{1'b0, 2'd0, 32'd0,   1, 1'b0, 0, 10,  1'b1};
    tbl[7]  = '{1'b0, 2'd0, 32'd0,   1, 1'b0, 1, 0,   1'b1};
    tbl[8]  = '{1'b0, 2'd0, 32'd0,   4, 1'b0, 1, 100, 1'b0};
    tbl[9]  = '{1'b1, 2'd3, 32'd0,   0, 1'b1, 1, 100, 1'b1};
    tbl[10] = '{1'b0, 2'd0, 32'd0,   3, 1'b0, 1, 25,  1'b1};
    tbl[11] = '{1'b0, 2'd0, 32'd0,   1, 1'b0, 3, 0,   1'b0};
    tbl[12] = '{1'b1, 2'd0, 32'd250, 0, 1'b1, 0, 0,   1'b1};
    tbl[13] = '{1'b0, 2'd0, 32'd0,   4, 1'b0, 0, 100, 1'b0};
    tbl[14] = '{1'b0, 2'd0, 32'd0,   1, 1'b0, 0, 100, 1'b0};
    tbl[15] = '{1'b1, 2'd0, 32'd40,  0, 1'b1, 0, 100, 1'b1};
    tbl[16] = '{1'b0, 2'd0, 32'd0,   2, 1'b0, 0, 50,  1'b1};
    tbl[17] = '{1'b0, 2'd0, 32'd0,   1, 1'b0, 0, 40,  1'b0};

    // Reset with a command offered: must not be accepted.
    rst = 1'b1; e_stop = 1'b0;
    cmd_valid = 1'b1; cmd_dir = 2'd0; cmd_speed = 32'd60;
    @(negedge clk);
    cycle();
    cycle();
    check("rst_dir", dir, 3);
    check("rst_duty", duty, 0);
    check("rst_busy", busy, 0);
    check("rst_wdog", wdog_trip, 0);
    check("rst_ready", cmd_ready, 0);
    check("period", period, PER);
    cmd_valid = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      if (tbl[i].valid) begin
        cmd_valid = 1'b1; cmd_dir = tbl[i].d; cmd_speed = tbl[i].spd;
        #1;
        check($sformatf("vec%0d_ready", i), cmd_ready, tbl[i].exp_ready);
        cycle();
        cmd_valid = 1'b0;
      end
      wait_ticks(tbl[i].ticks);
      check($sformatf("vec%0d_dir", i), dir, tbl[i].exp_dir);
      check($sformatf("vec%0d_duty", i), duty, tbl[i].exp_duty);
      check($sformatf("vec%0d_busy", i), busy, tbl[i].exp_busy);
    end

    // e_stop mid-ramp with a simultaneous command offer.
    offer(2'd0, 32'd100);
    wait_ticks(1);
    check("es_pre_duty", duty, 65);
    e_stop = 1'b1; cmd_valid = 1'b1; cmd_dir = 2'd0; cmd_speed = 32'd80;
    #1;
    check("es_ready", cmd_ready, 0);
    cycle();
    check("es_duty", duty, 0);
    check("es_dir", dir, 3);
    check("es_busy", busy, 0);
    e_stop = 1'b0; cmd_valid = 1'b0;
    cycle();
    check("es_post_dir", dir, 3);
    check("es_post_busy", busy, 0);

    // Watchdog: run at 50 with no further commands.
    offer(2'd0, 32'd50);
    wait_ticks(2);
    check("wd_run_duty", duty, 50);
    wait_ticks(5);
    check("wd_pre_trip", wdog_trip, 0);
    wait_ticks(1);
`ifdef MOTION_WDOG_EN
    check("wd_trip", wdog_trip, 1);
    check("wd_trip_busy", busy, 1);
`else
    check("wd_trip", wdog_trip, 0);
    check("wd_trip_busy", busy, 0);
`endif
    cycle();
    check("wd_trip_end", wdog_trip, 0);
    wait_ticks(2);
`ifdef MOTION_WDOG_EN
    check("wd_stop_duty", duty, 0);
    check("wd_stop_dir", dir, 3);
`else
    check("wd_hold_duty", duty, 50);
    check("wd_hold_dir", dir, 0);
    wait_ticks(12);
    check("wd_hold_duty2", duty, 50);
`endif

    // Randomized traffic against the model; valid/data held until accepted.
    for (int blk = 0; blk < 15; blk++) begin
      int rate;
      rate = (blk % 3 == 0) ? 60 : 5;
      for (int c = 0; c < 200; c++) begin
        int sel;
        rst = ($urandom_range(0, 999) == 0);
        e_stop = ($urandom_range(0, 99) == 0);
        if (!(cmd_valid && !m_acc)) begin
          cmd_valid = ($urandom_range(0, rate - 1) == 0);
          cmd_dir = 2'($urandom_range(0, 3));
          sel = $urandom_range(0, 7);
          if (sel == 0)      cmd_speed = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
          else if (sel == 1) cmd_speed = 32'd0;
          else               cmd_speed = 32'($urandom_range(0, 130));
        end
        cycle();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/motion_ramp_ctrl.md
Name: motion_ramp_ctrl

Overview:
- Sequencer between the remote-command decoder and the four-motor direction/PWM stage.
- Accepts (direction, speed) commands over a valid/ready handshake and drives the stage's direction code, PWM period and shared duty.
- Ramps the duty up and down in fixed steps for soft start and stop.
- On a direction change, ramps the duty to zero before switching direction, which protects the H-bridges.
- Stops the car on e-stop or on command-link watchdog expiry.

Parameters:
- N, 32, PWM counter/duty width.
- PERIOD, 85899, PWM period in clk cycles (1 kHz); driven constant on period output.
- STEP_DIV, 859, clk cycles per ramp tick (>=2).
- STEP, 4295, duty change per ramp tick (~5% of PERIOD).
- WDOG_TICKS, 500, ramp ticks without an accepted command before auto-stop.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when valid&ready
- cmd_dir  in  2  0 fwd, 1 left, 2 right, 3 stop
- cmd_speed  in  N  target duty in clk cycles
- e_stop  in  1  level emergency stop
- dir  out  2  direction code to PWM stage
- period  out  N  PWM period (=PERIOD)
- duty  out  N  shared duty, fanned to all four wheels by parent
- busy  out  1  ramp in progress
- wdog_trip  out  1  one-cycle pulse on watchdog expiry

Behaviour:
- Reset (rst high at posedge):
  - state=IDLE, dir=3, duty=0, busy=0, wdog_trip=0, tick counter=0, watchdog=0.
  - cmd_ready forced 0 while rst is high.
- cmd_ready is combinational: (state==IDLE || state==RUN) && !e_stop && !rst. Commands offered during ramps are held off; upstream must keep valid/data stable.
- Target: cmd_dir==3 -> 0; else min(cmd_speed, PERIOD). Compare at N bits, no truncation.
- Tick: free-running counter 0..STEP_DIV-1; tick asserts for 1 cycle when the counter equals STEP_DIV-1.
- States IDLE, RAMP_DN, RAMP_UP, RUN. Latency: state, tgt and pend_dir register 1 cycle after accept; duty first changes on the next tick.
- Accept in IDLE or RUN:
  - If cmd_dir==dir or duty==0: dir<=cmd_dir (unless cmd_dir==3 with duty!=0), tgt<=target. Then:
    - target>duty -> RAMP_UP
    - target<duty -> RAMP_DN
    - equal -> RUN, or IDLE if target==0
  - Else (direction change with duty!=0): pend_dir<=cmd_dir, pend_tgt<=target, tgt<=0, go RAMP_DN.
- RAMP_UP: on tick, duty<=min(duty+STEP, tgt), with N+1-bit add, no wrap. duty==tgt -> RUN.
- RAMP_DN: on tick, duty<=(duty>tgt+STEP)?duty-STEP:tgt, no underflow. On duty==tgt:
  - Pending direction: dir<=pend_dir, tgt<=pend_tgt, then RAMP_UP (or IDLE if pend_tgt==0).
  - Otherwise: RUN if tgt!=0; if tgt==0, dir<=3 and go IDLE.
- RUN with tgt==0 never persists; IDLE is the zero state.
- e_stop high: same cycle, next state IDLE, duty<=0, dir<=3, pending cleared. Overrides every other event, including a simultaneous cmd_valid (not accepted) and a watchdog trip.
- Watchdog:
  - Counts ticks while state!=IDLE; clears on any accept and in IDLE.
  - At WDOG_TICKS: wdog_trip pulses 1 cycle and an internal stop is applied exactly as an accepted cmd_dir=3 (ramp down, then IDLE). Counter is held at 0 until the next accept.
  - If an external accept coincides with expiry, the accept wins and no pulse is issued.
- busy = state is RAMP_UP or RAMP_DN.
- All outputs registered except cmd_ready. period output is constant PERIOD.

Optional Feature:
- Macro MOTION_WDOG_EN.
- Defined: watchdog as above.
- Undefined: watchdog counter not built, wdog_trip tied 0, car holds the last command indefinitely.

Decomposition:
- Package motion_pkg holds:
  - direction codes DIR_FWD=0, DIR_LEFT=1, DIR_RIGHT=2, DIR_STOP=3
  - state enum typedef
  - target-clamp helper function
- Sub-module ramp_tick_gen (STEP_DIV prescaler, synchronous active-high rst) produces the tick pulse.

Test Plan (PERIOD=100, STEP_DIV=4, STEP=25, WDOG_TICKS=8):
- Reset, then fwd speed 60 -> dir=0 one cycle after accept; duty 25,50,60 on successive ticks; busy low at 60; state RUN.
- In RUN fwd 60, command left 100 -> dir stays 0 while duty goes 35,10,0; then dir=1; duty 25..100; cmd_ready low throughout.
- Command fwd speed 250 -> clamped, duty ramps to 100 max; no wrap at 125.
- Stop (dir 3) from duty 100 -> 75,50,25,0, then dir=3, IDLE; cmd_ready back high.
- e_stop pulsed mid-ramp with cmd_valid high same cycle -> next cycle duty=0, dir=3, command not accepted.
- MOTION_WDOG_EN, RUN at 50, no commands -> wdog_trip single pulse after 8 ticks; duty ramps to 0; dir=3. Without the macro: duty stays 50, wdog_trip never asserts.
